usb2_ulpi: RTL and testbench



---
 rtl/usb2_ulpi.sv | 217 +++++++++++++++++++++
 tb/tb_usb2_ulpi.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb2_ulpi.sv
// ULPI link-layer wrapper for the 60 MHz phy_clk domain. It splits PHY
// traffic into RX CMD status and packet bytes, sends outgoing packets with
// turnaround handling, and issues ULPI register writes, including one
// automatic Function Control write after reset.
module usb2_ulpi #(
  parameter logic [7:0]  FUNC_CTRL_INIT = 8'h45,
  parameter logic [15:0] INIT_DELAY     = 16'd60000
) (
  input  logic       phy_clk,
  input  logic       reset,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  output logic       ulpi_stp,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_data_oe,
  output logic       in_act,
  output logic [7:0] in_byte,
  output logic       in_latch,
  output logic       out_cts,
  output logic       out_nxt,
  input  logic [7:0] out_byte,
  input  logic       out_latch,
  input  logic       out_stp,
  input  logic       reg_wr_req,
  input  logic [5:0] reg_addr,
  input  logic [7:0] reg_data,
  output logic       reg_done,
  output logic [1:0] line_state,
  output logic [1:0] vbus_state,
  output logic       rx_err,
  output logic       tx_abort,
  output logic       phy_ready
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_TX,
    ST_STP,
    ST_REG_CMD,
    ST_REG_DATA,
    ST_REG_STP
  } state_t;

  state_t      state, state_nx;
  logic        dir_1;
  logic        bus_free;
  logic [15:0] init_cnt, init_cnt_nx;
  logic [5:0]  wr_addr, wr_addr_nx;
  logic [7:0]  wr_data, wr_data_nx;
  logic        wr_init, wr_init_nx;
  logic [7:0]  data_nx;
  logic        stp_nx, abort_nx, done_nx, ready_nx;
  logic [7:0]  reg_cmd;

  assign bus_free     = ~ulpi_dir & ~dir_1;
  assign ulpi_data_oe = bus_free;
  assign out_cts      = (state == ST_IDLE) & bus_free & ~in_act & phy_ready;
  assign out_nxt      = (state == ST_TX) & ulpi_nxt & ~ulpi_dir;
  assign reg_cmd      = {2'b10, wr_addr};

  // Receive path: RX CMD status, packet bytes and RxActive tracking.
  always_ff @(posedge phy_clk) begin
    if (reset) begin
      dir_1      <= 1'b0;
      in_act     <= 1'b0;
      in_byte    <= '0;
      in_latch   <= 1'b0;
      line_state <= 2'b01;
      vbus_state <= 2'b00;
      rx_err     <= 1'b0;
    end else begin
      dir_1    <= ulpi_dir;
      in_latch <= 1'b0;
      if (ulpi_dir & dir_1) begin
        if (ulpi_nxt) begin
          in_byte  <= ulpi_data_in;
          in_latch <= 1'b1;
        end else begin
          line_state <= ulpi_data_in[1:0];
          vbus_state <= ulpi_data_in[3:2];
          in_act     <= ulpi_data_in[4];
          if (ulpi_data_in[5:4] == 2'b11) rx_err <= 1'b1;
        end
      end else if (ulpi_dir & ~dir_1) begin
        if (ulpi_nxt) in_act <= 1'b1;
      end else if (~ulpi_dir & dir_1) begin
        in_act <= 1'b0;
      end
    end
  end

  // Link-side state and registered bus drive.
  always_ff @(posedge phy_clk) begin
    if (reset) begin
      state         <= ST_INIT;
      init_cnt      <= '0;
      wr_addr       <= '0;
      wr_data       <= '0;
      wr_init       <= 1'b0;
      ulpi_data_out <= '0;
      ulpi_stp      <= 1'b0;
      tx_abort      <= 1'b0;
      reg_done      <= 1'b0;
      phy_ready     <= 1'b0;
    end else begin
      state         <= state_nx;
      init_cnt      <= init_cnt_nx;
      wr_addr       <= wr_addr_nx;
      wr_data       <= wr_data_nx;
      wr_init       <= wr_init_nx;
      ulpi_data_out <= data_nx;
      ulpi_stp      <= stp_nx;
      tx_abort      <= abort_nx;
      reg_done      <= done_nx;
      phy_ready     <= ready_nx;
    end
  end

  // Next-state and next-output decode for transmit and register writes.
  always_comb begin
    state_nx    = state;
    init_cnt_nx = init_cnt;
    wr_addr_nx  = wr_addr;
    wr_data_nx  = wr_data;
    wr_init_nx  = wr_init;
    data_nx     = ulpi_data_out;
    stp_nx      = 1'b0;
    abort_nx    = 1'b0;
    done_nx     = 1'b0;
    ready_nx    = phy_ready;
    case (state)
      ST_INIT: begin
        if (ulpi_dir) begin
          init_cnt_nx = '0;
        end else if (init_cnt == INIT_DELAY - 16'd1) begin
          init_cnt_nx = '0;
          wr_addr_nx  = 6'h04;
          wr_data_nx  = FUNC_CTRL_INIT;
          wr_init_nx  = 1'b1;
          data_nx     = {2'b10, 6'h04};
          state_nx    = ST_REG_CMD;
        end else begin
          init_cnt_nx = init_cnt + 16'd1;
        end
      end
      ST_IDLE: begin
        if (reg_wr_req & out_cts) begin
          wr_addr_nx = reg_addr;
          wr_data_nx = reg_data;
          wr_init_nx = 1'b0;
          data_nx    = {2'b10, reg_addr};
          state_nx   = ST_REG_CMD;
        end else if (out_latch & out_cts) begin
          data_nx  = out_byte;
          state_nx = ST_TX;
        end
      end
      ST_TX: begin
        if (ulpi_dir) begin
          abort_nx = 1'b1;
          data_nx  = '0;
          state_nx = ST_IDLE;
        end else if (out_stp) begin
          stp_nx   = 1'b1;
          data_nx  = '0;
          state_nx = ST_STP;
        end else if (ulpi_nxt) begin
          data_nx = out_byte;
        end
      end
      ST_STP: begin
        state_nx = ST_IDLE;
        if (ulpi_dir) begin
          abort_nx = 1'b1;
          data_nx  = '0;
        end
      end
      // After an interrupted write the bus is parked at 0; the command byte
      // is restated one cycle after the bus frees, and nxt only counts once
      // the command is actually on the bus.
      ST_REG_CMD: begin
        if (~bus_free) begin
          data_nx = '0;
        end else if (ulpi_data_out != reg_cmd) begin
          data_nx = reg_cmd;
        end else if (ulpi_nxt) begin
          data_nx  = wr_data;
          state_nx = ST_REG_DATA;
        end
      end
      ST_REG_DATA: begin
        if (ulpi_dir) begin
          data_nx  = '0;
          state_nx = ST_REG_CMD;
        end else if (ulpi_nxt) begin
          stp_nx   = 1'b1;
          data_nx  = '0;
          state_nx = ST_REG_STP;
        end
      end
      ST_REG_STP: begin
        if (ulpi_dir) begin
          data_nx  = '0;
          state_nx = ST_REG_CMD;
        end else begin
          state_nx = ST_IDLE;
          if (wr_init) ready_nx = 1'b1;
          else         done_nx  = 1'b1;
        end
      end
      default: state_nx = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_usb2_ulpi.sv
// Bench for usb2_ulpi: directed scenarios with literal expectations, then
// randomized PHY/host traffic checked each cycle against a behavioural model.
module tb_usb2_ulpi;

  localparam logic [15:0] INIT_DLY = 16'd16;
  localparam logic [7:0]  FC_INIT  = 8'h45;

  logic       phy_clk = 1'b0;
  logic       reset = 1'b1;
  logic       ulpi_dir = 1'b0;
  logic       ulpi_nxt = 1'b0;
  logic [7:0] ulpi_data_in = 8'h00;
  logic [7:0] out_byte = 8'h00;
  logic       out_latch = 1'b0;
  logic       out_stp = 1'b0;
  logic       reg_wr_req = 1'b0;
  logic [5:0] reg_addr = 6'h00;
  logic [7:0] reg_data = 8'h00;

  logic       ulpi_stp, ulpi_data_oe, in_act, in_latch, out_cts, out_nxt;
  logic       reg_done, rx_err, tx_abort, phy_ready;
  logic [7:0] ulpi_data_out, in_byte;
  logic [1:0] line_state, vbus_state;

  int checks = 0;
  int failures = 0;

  logic [7:0] rx_pkt [3] = '{8'h69, 8'h00, 8'h10};
  logic [7:0] tx_pkt [3] = '{8'h11, 8'h22, 8'h33};

  usb2_ulpi #(.FUNC_CTRL_INIT(FC_INIT), .INIT_DELAY(INIT_DLY)) dut (
    .phy_clk(phy_clk), .reset(reset),
    .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_stp(ulpi_stp),
    .ulpi_data_in(ulpi_data_in), .ulpi_data_out(ulpi_data_out),
    .ulpi_data_oe(ulpi_data_oe),
    .in_act(in_act), .in_byte(in_byte), .in_latch(in_latch),
    .out_cts(out_cts), .out_nxt(out_nxt), .out_byte(out_byte),
    .out_latch(out_latch), .out_stp(out_stp),
    .reg_wr_req(reg_wr_req), .reg_addr(reg_addr), .reg_data(reg_data),
    .reg_done(reg_done), .line_state(line_state), .vbus_state(vbus_state),
    .rx_err(rx_err), .tx_abort(tx_abort), .phy_ready(phy_ready)
  );

  always #5 phy_clk = ~phy_clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %02h, want %02h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Receive-side image
  bit         m_dir1, m_act, m_latch, m_err;
  logic [7:0] m_byte;
  logic [1:0] m_line, m_vbus;
  // Link-side activity flags
  bit         m_boot, m_tx, m_txstop, m_wr, m_shown, m_wrinit;
  bit         m_ready, m_stp, m_abort, m_done;
  int         m_wstep;
  int unsigned m_cnt;
  logic [7:0] m_bus, m_wval;
  logic [5:0] m_waddr;

  task automatic start_write(input logic [5:0] a, input logic [7:0] v, input bit is_init);
    m_wr = 1; m_wstep = 0; m_shown = 1;
    m_waddr = a; m_wval = v; m_wrinit = is_init;
    m_bus = {2'b10, a};
  endtask

  task automatic model_step();
    bit dir, nxt, busy, idle, cts;
    logic [7:0] d;
    dir = ulpi_dir; nxt = ulpi_nxt; d = ulpi_data_in;
    m_stp = 0; m_abort = 0; m_done = 0; m_latch = 0;
    if (reset) begin
      m_dir1 = 0; m_act = 0; m_err = 0; m_byte = 8'h00;
      m_line = 2'b01; m_vbus = 2'b00;
      m_boot = 1; m_cnt = 0; m_tx = 0; m_txstop = 0; m_wr = 0;
      m_shown = 0; m_wrinit = 0; m_ready = 0; m_bus = 8'h00;
      m_wstep = 0; m_waddr = 6'h00; m_wval = 8'h00;
      return;
    end
    busy = dir || m_dir1;
    idle = !(m_boot || m_tx || m_txstop || m_wr);
    cts  = idle && !busy && !m_act && m_ready;
    if (m_boot) begin
      if (dir) m_cnt = 0;
      else begin
        m_cnt++;
        if (m_cnt == INIT_DLY) begin
          m_boot = 0; m_cnt = 0;
          start_write(6'h04, FC_INIT, 1);
        end
      end
    end else if (m_tx) begin
      if (dir) begin m_abort = 1; m_bus = 8'h00; m_tx = 0; end
      else if (out_stp) begin m_stp = 1; m_bus = 8'h00; m_tx = 0; m_txstop = 1; end
      else if (nxt) m_bus = out_byte;
    end else if (m_txstop) begin
      m_txstop = 0;
      m_bus = 8'h00;
      if (dir) m_abort = 1;
    end else if (m_wr) begin
      if (m_wstep == 0) begin
        if (busy) begin m_bus = 8'h00; m_shown = 0; end
        else if (!m_shown) begin m_bus = {2'b10, m_waddr}; m_shown = 1; end
        else if (nxt) begin m_bus = m_wval; m_wstep = 1; end
      end else if (dir) begin
        m_bus = 8'h00; m_wstep = 0; m_shown = 0;
      end else if (m_wstep == 1) begin
        if (nxt) begin m_stp = 1; m_bus = 8'h00; m_wstep = 2; end
      end else begin
        m_wr = 0;
        if (m_wrinit) m_ready = 1; else m_done = 1;
      end
    end else if (reg_wr_req && cts) begin
      start_write(reg_addr, reg_data, 0);
    end else if (out_latch && cts) begin
      m_tx = 1; m_bus = out_byte;
    end
    // receive side
    if (dir && m_dir1) begin
      if (nxt) begin m_byte = d; m_latch = 1; end
      else begin
        m_line = d[1:0]; m_vbus = d[3:2]; m_act = d[4];
        if (d[5] && d[4]) m_err = 1;
      end
    end else if (dir && !m_dir1) begin
      if (nxt) m_act = 1;
    end else if (!dir && m_dir1) begin
      m_act = 0;
    end
    m_dir1 = dir;
  endtask

  task automatic compare_all();
    bit free, idle;
    free = !ulpi_dir && !m_dir1;
    idle = !(m_boot || m_tx || m_txstop || m_wr);
    check("ulpi_stp",      8'(ulpi_stp),      8'(m_stp));
    check("ulpi_data_out", ulpi_data_out,     m_bus);
    check("ulpi_data_oe",  8'(ulpi_data_oe),  8'(free));
    check("in_act",        8'(in_act),        8'(m_act));
    check("in_byte",       in_byte,           m_byte);
    check("in_latch",      8'(in_latch),      8'(m_latch));
    check("out_cts",       8'(out_cts),       8'(idle && free && !m_act && m_ready));
    check("out_nxt",       8'(out_nxt),       8'(m_tx && ulpi_nxt && !ulpi_dir));
    check("reg_done",      8'(reg_done),      8'(m_done));
    check("line_state",    8'(line_state),    8'(m_line));
    check("vbus_state",    8'(vbus_state),    8'(m_vbus));
    check("rx_err",        8'(rx_err),        8'(m_err));
    check("tx_abort",      8'(tx_abort),      8'(m_abort));
    check("phy_ready",     8'(phy_ready),     8'(m_ready));
  endtask

  // Per-cycle compare: model advances on the rising edge, outputs are
  // compared just after the falling edge once the new inputs are applied.
  initial begin
    forever begin
      @(posedge phy_clk);
      model_step();
      @(negedge phy_clk);
      #1;
      compare_all();
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge phy_clk);
  endtask

  task automatic phy(input logic dir, input logic nxt, input logic [7:0] d);
    ulpi_dir = dir; ulpi_nxt = nxt; ulpi_data_in = d;
  endtask

  initial begin
    int n;
    // reset held for two rising edges
    step(); step();
    check("reset line_state", 8'(line_state), 8'h01);
    check("reset phy_ready", 8'(phy_ready), 8'h00);
    check("reset ulpi_stp", 8'(ulpi_stp), 8'h00);
    reset = 1'b0;

    // init write: TXCMD 84 then 45, PHY nxt on second cycle of each phase
    n = 0;
    while (ulpi_data_out !== 8'h84 && n < 200) begin step(); n++; end
    check("init delay cycles", 8'(n), 8'(INIT_DLY));
    check("init TXCMD", ulpi_data_out, 8'h84);
    step(); phy(0, 1, 8'h00);
    step(); check("init data", ulpi_data_out, 8'h45); phy(0, 0, 8'h00);
    step(); phy(0, 1, 8'h00);
    step(); check("init stp", 8'(ulpi_stp), 8'h01);
    check("init stp data", ulpi_data_out, 8'h00); phy(0, 0, 8'h00);
    step(); check("init stp low", 8'(ulpi_stp), 8'h00);
    check("init phy_ready", 8'(phy_ready), 8'h01);
    #1 check("init out_cts", 8'(out_cts), 8'h01);

    // RX packet
    step(); phy(1, 1, 8'h00);
    step(); check("rx start in_act", 8'(in_act), 8'h01);
    for (int i = 0; i < 3; i++) begin
      phy(1, 1, rx_pkt[i]);
      step();
      check("rx in_latch", 8'(in_latch), 8'h01);
      check("rx in_byte", in_byte, rx_pkt[i]);
    end
    phy(1, 0, 8'h00);
    step(); check("rx end in_act", 8'(in_act), 8'h00);
    check("rx end line_state", 8'(line_state), 8'h00);
    phy(0, 0, 8'h00); step(); step();

    // TX ACK
    out_byte = 8'h4D; out_latch = 1'b1;
    #1 check("tx cts", 8'(out_cts), 8'h01);
    step(); out_latch = 1'b0;
    check("tx ack byte", ulpi_data_out, 8'h4D);
    step(); check("tx ack held", ulpi_data_out, 8'h4D);
    ulpi_nxt = 1'b1; out_stp = 1'b1;
    #1 check("tx out_nxt", 8'(out_nxt), 8'h01);
    step(); ulpi_nxt = 1'b0; out_stp = 1'b0;
    check("tx stp", 8'(ulpi_stp), 8'h01);
    check("tx stp data", ulpi_data_out, 8'h00);
    step(); check("tx stp one cycle", 8'(ulpi_stp), 8'h00);
    #1 check("tx cts back", 8'(out_cts), 8'h01);

    // TX abort on third data byte
    step(); out_byte = 8'h40; out_latch = 1'b1;
    step(); out_latch = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ulpi_nxt = 1'b1; out_byte = tx_pkt[i];
      step();
      check("tx data byte", ulpi_data_out, tx_pkt[i]);
    end
    phy(1, 0, 8'h01);
    #1 check("abort oe", 8'(ulpi_data_oe), 8'h00);
    step(); check("abort pulse", 8'(tx_abort), 8'h01);
    check("abort no stp", 8'(ulpi_stp), 8'h00);
    check("abort data", ulpi_data_out, 8'h00);
    step(); check("abort one cycle", 8'(tx_abort), 8'h00);
    phy(0, 0, 8'h00); step(); step();

    // RxError, then register write held off by the active receive
    phy(1, 0, 8'h01); step();
    phy(1, 0, 8'h31); step();
    check("rxerr rx_err", 8'(rx_err), 8'h01);
    check("rxerr line_state", 8'(line_state), 8'h01);
    check("rxerr in_act", 8'(in_act), 8'h01);
    reg_wr_req = 1'b1; reg_addr = 6'h04; reg_data = 8'h40;
    for (int i = 0; i < 4; i++) begin
      step();
      check("reg wait bus", ulpi_data_out, 8'h00);
      check("reg wait done", 8'(reg_done), 8'h00);
    end
    phy(0, 0, 8'h00); step(); step();
    check("reg cmd", ulpi_data_out, 8'h84);
    reg_wr_req = 1'b0; ulpi_nxt = 1'b1;
    step(); check("reg data", ulpi_data_out, 8'h40);
    step(); check("reg stp", 8'(ulpi_stp), 8'h01);
    ulpi_nxt = 1'b0;
    step(); check("reg done", 8'(reg_done), 8'h01);
    step(); check("reg done one cycle", 8'(reg_done), 8'h00);
    check("rx_err sticky", 8'(rx_err), 8'h01);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (ulpi_dir) begin
        if ($urandom_range(7) == 0) ulpi_dir = 1'b0;
      end else if ($urandom_range(24) == 0) begin
        ulpi_dir = 1'b1;
      end
      ulpi_nxt     = 1'($urandom_range(1));
      ulpi_data_in = 8'($urandom);
      out_latch    = ($urandom_range(5) == 0);
      out_stp      = ($urandom_range(5) == 0);
      out_byte     = 8'($urandom);
      reg_wr_req   = ($urandom_range(15) == 0);
      reg_addr     = 6'($urandom);
      reg_data     = 8'($urandom);
      reset        = ($urandom_range(799) == 0);
      step();
    end

    // reset mid-operation, then init write reissues
    reset = 1'b1; phy(0, 0, 8'h00);
    out_latch = 1'b0; out_stp = 1'b0; reg_wr_req = 1'b0;
    step();
    check("rst phy_ready", 8'(phy_ready), 8'h00);
    check("rst rx_err", 8'(rx_err), 8'h00);
    check("rst line_state", 8'(line_state), 8'h01);
    check("rst in_act", 8'(in_act), 8'h00);
    reset = 1'b0; ulpi_nxt = 1'b1;
    n = 0;
    while (phy_ready !== 1'b1 && n < 100) begin step(); n++; end
    check("reinit phy_ready", 8'(phy_ready), 8'h01);
    ulpi_nxt = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
